// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron datapath blocks (accumulator, activation).
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package nn_pkg;

    // Default sizing used across the NN blocks.
    localparam int NN_WIDTH   = 32;
    localparam int NN_MAX_LEN = 64;

    // Widest sum sat_to_width can inspect; every ACC_W in the datapath must fit.
    localparam int SAT_MAX_W  = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FULL = 2'd2
    } acc_state_t;

    // Returns 1 when the sign-extended sum does not fit in a signed field of 'width' bits.
    function automatic logic sat_to_width(input logic signed [SAT_MAX_W-1:0] sum,
                                          input int unsigned                 width);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = SAT_MAX_W'(1) <<< (width - 1);
        hi = hi - SAT_MAX_W'(1);
        lo = ~hi;
        return (sum > hi) || (sum < lo);
    endfunction

endpackage

// File: rtl/sat_round.sv
// Narrows a wide signed sum to WIDTH bits: clamp (SATURATE=1) or wrap (SATURATE=0), flags overflow.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module sat_round
    import nn_pkg::*;
#(
    parameter int WIDTH    = NN_WIDTH,
    parameter int ACC_W    = NN_WIDTH + 7,
    parameter int SATURATE = 1
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [WIDTH-1:0] result,
    output logic                    ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [SAT_MAX_W-1:0] sum_ext;

    assign sum_ext = SAT_MAX_W'(sum);

    // Overflow is reported in both modes; only the clamp depends on SATURATE.
    always_comb begin
        ovf    = sat_to_width(sum_ext, WIDTH);
        result = sum[WIDTH-1:0];
        if ((SATURATE != 0) && ovf) begin
            result = sum[ACC_W-1] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/stream_accumulator.sv
// Sums a bias-seeded frame of signed beats into one saturated/wrapped result per frame.
// Latency: result on out_* one cycle after the closing beat is accepted.
// Backpressure: in_ready drops only while a result is held and out_ready is low.
module stream_accumulator
    import nn_pkg::*;
#(
    parameter int WIDTH    = NN_WIDTH,
    parameter int MAX_LEN  = NN_MAX_LEN,
    parameter int SATURATE = 1,
    localparam int CNT_W   = $clog2(MAX_LEN + 1),
    localparam int ACC_W   = WIDTH + $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_bias,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_len,
    output logic             out_ovf,
    output logic             out_trunc
);

    acc_state_t              state;
    acc_state_t              state_next;
    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;

    logic                    accept;
    logic                    first_beat;
    logic                    close;
    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic        [CNT_W-1:0] cnt_next;
    logic        [WIDTH-1:0] sat_data;
    logic                    sat_ovf;

    // A held result being taken this cycle frees the slot for a new first beat.
    assign in_ready   = ~rst & ((state != FULL) | out_ready);
    assign accept     = in_valid & in_ready;
    assign out_valid  = (state == FULL);

    // Any accepted beat outside ACC opens a new frame (from FULL only when out_ready).
    assign first_beat = (state != ACC);
    assign data_ext   = {{(ACC_W-WIDTH){in_data[WIDTH-1]}}, in_data};
    assign bias_ext   = {{(ACC_W-WIDTH){in_bias[WIDTH-1]}}, in_bias};
    assign acc_next   = first_beat ? (bias_ext + data_ext) : (acc + data_ext);
    assign cnt_next   = first_beat ? CNT_W'(1) : (cnt + CNT_W'(1));
    assign close      = in_last | (cnt_next == CNT_W'(MAX_LEN));

    sat_round #(
        .WIDTH    (WIDTH),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_round (
        .sum    (acc_next),
        .result (sat_data),
        .ovf    (sat_ovf)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a closing beat always lands in FULL, even straight out of FULL.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACC: begin
                if (accept) begin
                    state_next = close ? FULL : ACC;
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (accept) begin
                        state_next = close ? FULL : ACC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Running sum/count, and the result captured on the beat that closes a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_len   <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (close) begin
                out_data  <= sat_data;
                out_len   <= cnt_next;
                out_ovf   <= sat_ovf;
                out_trunc <= ~in_last;
            end
        end
    end

endmodule

// File: tb/tb_stream_accumulator.sv
// Bench for stream_accumulator at WIDTH=8, MAX_LEN=4, saturating and wrapping instances side by side.
// Latency: checks out_* one cycle after each accepted closing beat.
// Backpressure: drives out_ready low on purpose and expects in_ready to follow.
module tb_stream_accumulator;

    localparam int W     = 8;
    localparam int ML    = 4;
    localparam int CW    = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [W-1:0]  in_bias;
    logic          in_last;
    logic          out_ready;

    logic          in_ready_s, out_valid_s, out_ovf_s, out_trunc_s;
    logic [W-1:0]  out_data_s;
    logic [CW-1:0] out_len_s;
    logic          in_ready_w, out_valid_w, out_ovf_w, out_trunc_w;
    logic [W-1:0]  out_data_w;
    logic [CW-1:0] out_len_w;

    int total = 0;
    int bad   = 0;

    // Reference model: open frame sum/length and the currently held expected result.
    bit            m_open = 0;
    bit            m_pend = 0;
    int            m_sum  = 0;
    int            m_len  = 0;
    logic [W-1:0]  e_sat, e_wrap;
    logic [CW-1:0] e_len;
    logic          e_ovf, e_trunc;

    always #5 clk = ~clk;

    stream_accumulator #(.WIDTH(W), .MAX_LEN(ML), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_bias(in_bias), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_len(out_len_s), .out_ovf(out_ovf_s), .out_trunc(out_trunc_s)
    );

    stream_accumulator #(.WIDTH(W), .MAX_LEN(ML), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_bias(in_bias), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_len(out_len_w), .out_ovf(out_ovf_w), .out_trunc(out_trunc_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result straight from the arithmetic: clamp or two's-complement wrap to 8 bits.
    task automatic model_close(input bit last);
        e_ovf   = (m_sum > 127) || (m_sum < -128);
        e_wrap  = 8'(m_sum);
        e_sat   = (m_sum > 127) ? 8'h7F : (m_sum < -128) ? 8'h80 : 8'(m_sum);
        e_len   = CW'(m_len);
        e_trunc = !last;
        m_pend  = 1;
        m_open  = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid_s", out_valid_s, m_pend);
        chk("out_valid_w", out_valid_w, m_pend);
        if (m_pend) begin
            chk("data_sat",  out_data_s,  e_sat);
            chk("data_wrap", out_data_w,  e_wrap);
            chk("len",       out_len_s,   e_len);
            chk("len_w",     out_len_w,   e_len);
            chk("ovf_s",     out_ovf_s,   e_ovf);
            chk("ovf_w",     out_ovf_w,   e_ovf);
            chk("trunc",     out_trunc_s, e_trunc);
            chk("trunc_w",   out_trunc_w, e_trunc);
        end
    endtask

    // One clock of stimulus; inputs change and outputs are sampled 1 time unit past the edge.
    task automatic step(input bit v, input int bias, input int data, input bit last);
        bit rdy;
        in_valid = v;
        in_bias  = 8'(bias);
        in_data  = 8'(data);
        in_last  = last;
        #1;
        rdy = !(m_pend && !out_ready);
        chk("in_ready_s", in_ready_s, rdy);
        chk("in_ready_w", in_ready_w, rdy);
        @(posedge clk);
        #1;
        if (out_ready) m_pend = 0;
        if (v && rdy) begin
            if (!m_open) begin
                m_sum  = bias + data;
                m_len  = 1;
                m_open = 1;
            end else begin
                m_sum  = m_sum + data;
                m_len  = m_len + 1;
            end
            if (last || (m_len == ML)) model_close(last);
        end
        check_outputs();
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid_s, 1'b0);
        chk("rst_in_ready",  in_ready_s,  1'b0);
        chk("rst_out_data",  out_data_s,  8'h00);
        chk("rst_out_len",   out_len_s,   3'd0);
        chk("rst_ovf",       out_ovf_s,   1'b0);
        chk("rst_trunc",     out_trunc_s, 1'b0);
        chk("rst_out_valid_w", out_valid_w, 1'b0);
        m_open = 0;
        m_pend = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bias   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("reset_out_valid", out_valid_s, 1'b0);
        chk("reset_in_ready",  in_ready_s,  1'b0);
        chk("reset_out_data",  out_data_s,  8'h00);
        chk("reset_out_len",   out_len_s,   3'd0);
        chk("reset_ovf",       out_ovf_s,   1'b0);
        chk("reset_trunc",     out_trunc_s, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Basic frame: 3 + 5 - 2 + 10 = 16; bias on later beats must be ignored.
        step(1, 3, 5, 0);
        step(1, 77, -2, 0);
        step(1, -9, 10, 1);
        chk("basic_sum", out_data_s, 8'd16);

        // Overflow both ways, then idle cycle.
        step(1, 100, 20, 0);
        step(1, 0, 30, 1);
        step(1, -100, -50, 0);
        step(1, 0, -1, 1);
        step(0, 55, 55, 1);

        // MAX_LEN closes a frame; fifth beat starts a new one; last on 4th beat is not truncated.
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        step(0, 0, 0, 0);

        // Single-beat frame, then hold the result against a waiting beat.
        step(1, 2, 3, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 9, 9, 0);
        out_ready = 1'b1;
        step(1, 9, 9, 0);
        step(1, 0, 1, 1);
        step(0, 0, 0, 0);

        // Reset while a result is held, then reset mid-frame after two beats.
        step(1, 4, 4, 1);
        out_ready = 1'b0;
        step(0, 0, 0, 0);
        do_reset();
        out_ready = 1'b1;
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        do_reset();
        step(0, 0, 0, 0);
        step(1, 0, 7, 1);
        step(0, 0, 0, 0);

        // Random traffic with random gaps and downstream stalls.
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) begin
                step(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
            end else begin
                step(1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     $urandom_range(0, 3) == 0);
            end
        end
        out_ready = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
